low_frequency_square_wave_generator: RTL and testbench
======================================================

# low_frequency_square_wave_generator

Programmable square-wave source for 1–9999 Hz, set by a 4-digit BCD frequency word. It is the stimulus-side counterpart of the auto-scaled low-frequency counter: the same BCD-to-binary, divide and period-counting chain, run in reverse. On a start pulse it validates the BCD input, converts it to binary and computes the half-period in microseconds with a sequential divider. It then toggles `wave_o` from a microsecond prescaler until restarted or reset.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000, system clock frequency; must be an integer multiple of 1_000_000.
- `CLKS_PER_US` (localparam), equal to CLK_FREQ_HZ/1_000_000; prescaler terminal count.

- `clk_i`  in  1  system clock; one clock domain, all logic on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle pulse; samples `bcd_i` and (re)starts generation.
- `bcd_i`  in  16  frequency in Hz as 4 BCD digits, [15:12] most significant.
- `ready_o`  out  1  high in IDLE and RUN, when a start is accepted.
- `done_o`  out  1  one-cycle pulse on entering RUN.
- `error_o`  out  1  level; last accepted start had an illegal `bcd_i`.
- `wave_o`  out  1  generated square wave.
- `edge_o`  out  1  one-cycle pulse on every rising edge of `wave_o`.
- `half_period_o`  out  20  computed half-period in µs; valid from `done_o` onward.

## Operation
- States: IDLE, BCD2BIN, DIVIDE, RUN.
- IDLE
  - `wave_o` = 0.
  - On `start_i`: if any digit > 9, or `bcd_i` == 0, set `error_o` and stay in IDLE.
  - Otherwise clear `error_o`, latch `bcd_i` and go to BCD2BIN.
- BCD2BIN
  - 4 cycles, most significant digit first: bin = bin*10 + digit.
  - bin is 14 bits wide; the maximum is 9999.
- DIVIDE
  - Restoring division of the constant 500_000 (20 bits) by bin, one quotient bit per cycle, 20 cycles.
  - Quotient is truncated and the remainder is discarded.
  - Result range: 50 (9999 Hz) to 500_000 (1 Hz).
- RUN
  - On entry: `half_period_o` ← quotient, `wave_o` ← 1, `edge_o` ← 1, `done_o` ← 1, prescaler and µs counter cleared.
  - The prescaler pulses every CLKS_PER_US cycles.
  - The µs counter increments on each prescaler pulse.
  - When the counter reaches `half_period_o`: toggle `wave_o` and clear the counter. A 0→1 toggle also pulses `edge_o`.
- `start_i` in RUN
  - Handled exactly as in IDLE.
  - `wave_o` is forced to 0 the next cycle and counters are cleared.
  - On error, return to IDLE.
- `start_i` in BCD2BIN or DIVIDE is ignored (`ready_o` = 0).
- `reset_i` at any time, including mid-division, returns to IDLE.
  - Reset values: `wave_o` 0, `edge_o` 0, `done_o` 0, `error_o` 0, `half_period_o` 0, `ready_o` 1.

## Timing
- Start sampled at edge 0.
  - BCD2BIN occupies cycles 1–4.
  - DIVIDE occupies cycles 5–24.
  - `done_o` = 1 and `wave_o` rises in cycle 25.
- Error path: `error_o` goes high in cycle 1 and `ready_o` stays 1.
- Each high or low phase of `wave_o` lasts exactly `half_period_o` × CLKS_PER_US cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package contents:
  - state typedef `sqgen_state_t`;
  - `SQGEN_DIVIDEND` = 500_000;
  - `SQGEN_Q_BITS` = 20;
  - `SQGEN_BIN_BITS` = 14.
- Sub-module `period_divider`: start/done restoring divider, parameterised by dividend and divisor widths, owning the 20-cycle iteration.
- The top level holds the FSM, BCD2BIN, prescaler and half-period counter.

## Test plan
Bench uses CLK_FREQ_HZ = 2_000_000, so CLKS_PER_US = 2.
- Reset asserted for 3 cycles → `wave_o` = 0, `ready_o` = 1, `done_o`/`error_o`/`edge_o` = 0, `half_period_o` = 0.
- Start with 0x1000 → `done_o` exactly 25 cycles later, `half_period_o` = 500; `wave_o` high for 1000 cycles, then low for 1000; one `edge_o` pulse per 2000 cycles.
- Start with 0x9999 → `half_period_o` = 50, phases of 100 cycles. Start with 0x0001 → `half_period_o` = 500_000.
- Start with 0x0000, then with 0x12A4 → `error_o` = 1 in cycle 1; state stays IDLE; `wave_o` = 0; no `done_o`.
- In RUN, start with 0x0050 → `wave_o` = 0 the next cycle; `done_o` 25 cycles after the start; `half_period_o` = 10_000. A `start_i` pulse at cycle 10 of DIVIDE is ignored.
- Reset at DIVIDE cycle 12 → IDLE with all reset values. A following start with 0x0002 produces `half_period_o` = 250_000.

Source files
------------

// File: rtl/low_frequency_square_wave_generator_pkg.sv
// Shared definitions for the low-frequency square-wave generator.
//   sqgen_state_t  : top-level FSM states
//   SQGEN_*        : divider widths and the half-period dividend (1e6/2 us)
//   sqgen_bcd_legal: true when every BCD digit is 0..9 and the word is non-zero
package low_frequency_square_wave_generator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BCD2BIN = 2'd1,
      ST_DIVIDE  = 2'd2,
      ST_RUN     = 2'd3
   } sqgen_state_t;

   localparam int SQGEN_Q_BITS   = 20;
   localparam int SQGEN_BIN_BITS = 14;
   // Half of one second in microseconds: half-period = 500_000 / f.
   localparam logic [SQGEN_Q_BITS-1:0] SQGEN_DIVIDEND = 20'd500_000;

   function automatic logic sqgen_bcd_legal(input logic [15:0] bcd);
      logic ok;
      ok = (bcd != 16'h0000);
      for (int d = 0; d < 4; d++) begin
         if (bcd[d*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/low_frequency_square_wave_generator_if.sv
// Control/status bundle of the square-wave generator.
//   start_i/bcd_i      : start pulse and 4-digit BCD frequency (driven by master)
//   ready_o/done_o/error_o/wave_o/edge_o/half_period_o : status and output
//                        wave (driven by the generator, slave side)
interface low_frequency_square_wave_generator_if;
   import low_frequency_square_wave_generator_pkg::*;

   logic                    start_i;
   logic [15:0]             bcd_i;
   logic                    ready_o;
   logic                    done_o;
   logic                    error_o;
   logic                    wave_o;
   logic                    edge_o;
   logic [SQGEN_Q_BITS-1:0] half_period_o;

   modport master (
      output start_i, bcd_i,
      input  ready_o, done_o, error_o, wave_o, edge_o, half_period_o
   );

   modport slave (
      input  start_i, bcd_i,
      output ready_o, done_o, error_o, wave_o, edge_o, half_period_o
   );

endinterface

// File: rtl/low_frequency_square_wave_generator_period_divider.sv
// Restoring divider, one quotient bit per cycle, DIVIDEND_W iterations.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : loads dividend_i/divisor_i; iteration starts next cycle
//   dividend_i     : numerator (DIVIDEND_W bits)
//   divisor_i      : denominator (DIVISOR_W bits), must be non-zero
//   done_o         : high during the final iteration cycle
//   quot_o         : quotient as it will be after the current iteration;
//                    holds the final truncated quotient while done_o is high
// done_o/quot_o are exposed a cycle early so the caller can register the
// result on the same edge as the last iteration, keeping its latency exact.
module period_divider #(
   parameter int DIVIDEND_W = 20,
   parameter int DIVISOR_W  = 14
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [DIVIDEND_W-1:0] dividend_i,
   input  logic [DIVISOR_W-1:0]  divisor_i,
   output logic                  done_o,
   output logic [DIVIDEND_W-1:0] quot_o
);

   localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

   logic [DIVIDEND_W-1:0] quot_q, quot_nxt;
   logic [DIVISOR_W-1:0]  rem_q, rem_nxt, div_q;
   logic [DIVISOR_W:0]    rem_sh;
   logic [CNT_W-1:0]      cnt_q;
   logic                  busy_q;
   logic                  take;

   // Quotient register doubles as the dividend shift register: its MSB
   // feeds the partial remainder and the new quotient bit enters at the LSB.
   always_comb begin
      rem_sh   = {rem_q, quot_q[DIVIDEND_W-1]};
      take     = (rem_sh >= {1'b0, div_q});
      rem_nxt  = take ? DIVISOR_W'(rem_sh - {1'b0, div_q}) : rem_sh[DIVISOR_W-1:0];
      quot_nxt = {quot_q[DIVIDEND_W-2:0], take};
   end

   assign done_o = busy_q && (cnt_q == CNT_W'(DIVIDEND_W-1));
   assign quot_o = quot_nxt;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         div_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         quot_q <= dividend_i;
         rem_q  <= '0;
         div_q  <= divisor_i;
      end else if (busy_q) begin
         quot_q <= quot_nxt;
         rem_q  <= rem_nxt;
         cnt_q  <= cnt_q + CNT_W'(1);
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/low_frequency_square_wave_generator.sv
// Programmable 1..9999 Hz square-wave source.
//   clk_i   : system clock (CLK_FREQ_HZ, integer multiple of 1 MHz)
//   reset_i : synchronous active-high reset
//   bus     : slave side of low_frequency_square_wave_generator_if
//             (start_i/bcd_i in; ready_o, done_o, error_o, wave_o, edge_o,
//             half_period_o out, all registered)
// A start validates the BCD word, converts it to binary over 4 cycles,
// divides 500_000 by it over 20 cycles and then toggles wave_o every
// half_period_o microseconds.
module low_frequency_square_wave_generator
   import low_frequency_square_wave_generator_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000
) (
   input  logic clk_i,
   input  logic reset_i,
   low_frequency_square_wave_generator_if.slave bus
);

   localparam int CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
   localparam int PRESC_W     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

   sqgen_state_t              state_q;
   logic [15:0]               bcd_q;
   logic [1:0]                dig_q;
   logic [SQGEN_BIN_BITS-1:0] bin_q, bin_nxt;
   logic [PRESC_W-1:0]        presc_q;
   logic [SQGEN_Q_BITS-1:0]   us_q, half_q, div_quot;
   logic                      ready_q, done_q, error_q, wave_q, edge_q;
   logic                      div_start, div_done;

   // Digits are consumed from the top nibble of a left-shifting copy.
   assign bin_nxt   = bin_q * SQGEN_BIN_BITS'(10) + SQGEN_BIN_BITS'(bcd_q[15:12]);
   // The divider loads the fully converted value on the last BCD2BIN edge.
   assign div_start = (state_q == ST_BCD2BIN) && (dig_q == 2'd3);

   period_divider #(
      .DIVIDEND_W (SQGEN_Q_BITS),
      .DIVISOR_W  (SQGEN_BIN_BITS)
   ) u_div (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .start_i    (div_start),
      .dividend_i (SQGEN_DIVIDEND),
      .divisor_i  (bin_nxt),
      .done_o     (div_done),
      .quot_o     (div_quot)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         bcd_q   <= '0;
         dig_q   <= '0;
         bin_q   <= '0;
         presc_q <= '0;
         us_q    <= '0;
         half_q  <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         wave_q  <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         edge_q <= 1'b0;
         if (bus.start_i && (state_q == ST_IDLE || state_q == ST_RUN)) begin
            // A (re)start always silences the output and clears timing.
            wave_q  <= 1'b0;
            presc_q <= '0;
            us_q    <= '0;
            if (!sqgen_bcd_legal(bus.bcd_i)) begin
               error_q <= 1'b1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end else begin
               error_q <= 1'b0;
               ready_q <= 1'b0;
               bcd_q   <= bus.bcd_i;
               bin_q   <= '0;
               dig_q   <= '0;
               state_q <= ST_BCD2BIN;
            end
         end else begin
            case (state_q)
               ST_IDLE: wave_q <= 1'b0;
               ST_BCD2BIN: begin
                  bin_q <= bin_nxt;
                  bcd_q <= {bcd_q[11:0], 4'h0};
                  dig_q <= dig_q + 2'd1;
                  if (dig_q == 2'd3) state_q <= ST_DIVIDE;
               end
               ST_DIVIDE: begin
                  if (div_done) begin
                     half_q  <= div_quot;
                     wave_q  <= 1'b1;
                     edge_q  <= 1'b1;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     presc_q <= '0;
                     us_q    <= '0;
                     state_q <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (presc_q == PRESC_W'(CLKS_PER_US - 1)) begin
                     presc_q <= '0;
                     // Toggle on the tick that completes the half-period.
                     if ((us_q + SQGEN_Q_BITS'(1)) == half_q) begin
                        us_q   <= '0;
                        wave_q <= ~wave_q;
                        edge_q <= ~wave_q;
                     end else begin
                        us_q <= us_q + SQGEN_Q_BITS'(1);
                     end
                  end else begin
                     presc_q <= presc_q + PRESC_W'(1);
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.ready_o       = ready_q;
   assign bus.done_o        = done_q;
   assign bus.error_o       = error_q;
   assign bus.wave_o        = wave_q;
   assign bus.edge_o        = edge_q;
   assign bus.half_period_o = half_q;

endmodule

// File: tb/tb_low_frequency_square_wave_generator.sv
// Self-checking bench for low_frequency_square_wave_generator at 2 MHz
// (2 clocks per microsecond). Expected values come from the frequency
// itself: half-period = 500_000 / f, phase length = 2 * half-period clocks.
module tb_low_frequency_square_wave_generator;

   localparam int CLK_HZ = 2_000_000;
   localparam int K      = CLK_HZ / 1_000_000;

   logic clk;
   logic reset;
   int   n_asserts = 0;
   int   n_fails   = 0;

   low_frequency_square_wave_generator_if bif();

   low_frequency_square_wave_generator #(.CLK_FREQ_HZ(CLK_HZ)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: decimal frequency -> BCD word.
   function automatic logic [15:0] to_bcd(input int f);
      return {4'(f / 1000), 4'((f / 100) % 10), 4'((f / 10) % 10), 4'(f % 10)};
   endfunction

   // Pulse start for one edge; returns in cycle 1 after the sampling edge.
   task automatic do_start(input logic [15:0] bcd);
      bif.bcd_i   = bcd;
      bif.start_i = 1'b1;
      tick();
      bif.start_i = 1'b0;
   endtask

   task automatic start_and_wait(input logic [15:0] bcd, input int exp_half, input int inj_cyc);
      int cyc;
      do_start(bcd);
      check("ready_busy", bif.ready_o, 0);
      check("error_clear", bif.error_o, 0);
      check("wave_off_c1", bif.wave_o, 0);
      cyc = 1;
      while (bif.done_o !== 1'b1 && cyc < 100) begin
         if (cyc == inj_cyc) begin
            check("ready_in_divide", bif.ready_o, 0);
            bif.bcd_i   = 16'h0001;
            bif.start_i = 1'b1;
         end
         tick();
         bif.start_i = 1'b0;
         cyc++;
      end
      check("done_latency", cyc, 25);
      check("half_period", bif.half_period_o, exp_half);
      check("wave_rise", bif.wave_o, 1);
      check("edge_on_entry", bif.edge_o, 1);
      check("ready_run", bif.ready_o, 1);
   endtask

   // Length of the current wave phase, counting the present cycle, plus any
   // edge/done pulses seen after the first cycle of the phase.
   task automatic measure(output int len, output int edges, output int dones);
      logic v;
      v = bif.wave_o;
      len = 1; edges = 0; dones = 0;
      forever begin
         tick();
         if (bif.wave_o !== v || len > 5000) break;
         len++;
         edges += int'(bif.edge_o);
         dones += int'(bif.done_o);
      end
   endtask

   task automatic err_start(input string tag, input logic [15:0] bcd);
      int seen;
      do_start(bcd);
      check({tag, "_error"}, bif.error_o, 1);
      check({tag, "_ready"}, bif.ready_o, 1);
      check({tag, "_wave"}, bif.wave_o, 0);
      seen = 0;
      repeat (30) begin
         tick();
         seen += int'(bif.done_o) + int'(bif.wave_o);
      end
      check({tag, "_idle"}, seen, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wave"}, bif.wave_o, 0);
      check({tag, "_ready"}, bif.ready_o, 1);
      check({tag, "_done"}, bif.done_o, 0);
      check({tag, "_error"}, bif.error_o, 0);
      check({tag, "_edge"}, bif.edge_o, 0);
      check({tag, "_half"}, bif.half_period_o, 0);
   endtask

   initial begin
      int len, edges, dones, f, h, seen;
      logic [15:0] bad;

      reset       = 1'b1;
      bif.start_i = 1'b0;
      bif.bcd_i   = 16'h0000;
      repeat (3) tick();
      check_reset_values("reset");
      reset = 1'b0;
      tick();

      // 1000 Hz: half 500 us = 1000 clocks per phase.
      start_and_wait(16'h1000, 500, 0);
      measure(len, edges, dones);
      check("1k_high_len", len, 500 * K);
      check("1k_high_edges", edges, 0);
      check("1k_done_pulse", dones, 0);
      measure(len, edges, dones);
      check("1k_low_len", len, 500 * K);
      check("1k_low_edges", edges, 0);
      check("1k_rise_edge", bif.edge_o, 1);
      check("1k_wave_high", bif.wave_o, 1);

      // Random frequencies, restarted while running.
      for (int i = 0; i < 3; i++) begin
         f = int'($urandom_range(1000, 9999));
         h = 500_000 / f;
         start_and_wait(to_bcd(f), h, 0);
         measure(len, edges, dones);
         check("rnd_high_len", len, h * K);
      end

      // 9999 Hz: minimum half-period.
      start_and_wait(16'h9999, 50, 0);
      measure(len, edges, dones);
      check("9999_high_len", len, 100);
      measure(len, edges, dones);
      check("9999_low_len", len, 100);
      check("9999_rise_edge", bif.edge_o, 1);

      // Restart in RUN with a start pulse injected at DIVIDE cycle 10.
      start_and_wait(16'h0050, 10_000, 14);

      // 1 Hz: maximum half-period.
      start_and_wait(16'h0001, 500_000, 0);

      // Illegal words, the first issued while running.
      err_start("zero", 16'h0000);
      err_start("hex_digit", 16'h12A4);
      bad = 16'($urandom);
      bad[$urandom_range(0, 3) * 4 +: 4] = 4'($urandom_range(10, 15));
      err_start("rnd_illegal", bad);

      // Reset in the middle of division.
      do_start(16'h0123);
      check("mid_error_clear", bif.error_o, 0);
      repeat (15) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_values("mid_reset");
      seen = 0;
      repeat (40) begin
         tick();
         seen += int'(bif.done_o) + int'(bif.wave_o);
      end
      check("mid_reset_idle", seen, 0);

      start_and_wait(16'h0002, 250_000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
